// File: rtl/arbiter_4ch.sv
// arbiter_4ch: four-requester arbiter with fixed/round-robin priority and bounded hold time
module arbiter_4ch #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  input  logic       rr_en,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, gnt_id_n, fix_win, rr_win;
  logic [3:0] hold, hold_n, gnt_n;
  logic busy_n, timeout_n, own_req, rel;
  always_comb begin
    fix_win = 2'd0;
    for (int i = 0; i < 4; i++) fix_win = req[i] ? 2'(i) : fix_win;
    rr_win = ptr;
    // scan backwards so the bit closest to ptr is the last one written
    for (int i = 3; i >= 0; i--) rr_win = req[ptr + 2'(i)] ? ptr + 2'(i) : rr_win;
  end
  assign own_req = req[gnt_id];
  assign rel = done || !own_req || hold == 4'(MAX_HOLD);
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    gnt_id_n = gnt_id;
    busy_n = busy;
    timeout_n = 1'b0;
    hold_n = hold;
    ptr_n = ptr;
    case (state)
      IDLE: if (|req) begin
        state_n = GRANT;
        gnt_id_n = rr_en ? rr_win : fix_win;
        gnt_n = 4'b0001 << gnt_id_n;
        busy_n = 1'b1;
        hold_n = 4'd1;
      end
      GRANT: if (rel) begin
        state_n = RELEASE;
        gnt_n = 4'b0000;
        busy_n = 1'b0;
        timeout_n = !done && own_req;
        hold_n = 4'd0;
        ptr_n = gnt_id + 2'd1;
      end else hold_n = hold + 4'd1;
      default: begin
        state_n = IDLE;
        gnt_n = 4'b0000;
        busy_n = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= 4'b0000;
      gnt_id <= 2'd0;
      busy <= 1'b0;
      timeout <= 1'b0;
      hold <= 4'd0;
      ptr <= 2'd0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      gnt_id <= gnt_id_n;
      busy <= busy_n;
      timeout <= timeout_n;
      hold <= hold_n;
      ptr <= ptr_n;
    end
  end
endmodule

// File: tb/tb_arbiter_4ch.sv
// tb_arbiter_4ch: directed and random stimulus against a behavioural arbiter model via a scoreboard queue
module tb_arbiter_4ch;
  localparam int MAX_HOLD = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic done = 1'b0;
  logic rr_en = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic busy, timeout;
  arbiter_4ch #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .rr_en(rr_en),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int m_phase = 0, m_owner = 0, m_hold = 0, m_ptr = 0;
  bit m_to = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int pick(input logic [3:0] r, input bit rr);
    if (!rr) begin
      for (int i = 3; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 0; k < 4; k++) if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return 0;
  endfunction
  // phase: 0 waiting, 1 someone owns the resource, 2 mandatory gap cycle
  task automatic model(input logic [3:0] r, input bit d, input bit rr, input bit rs);
    bit own;
    if (rs) begin
      m_phase = 0; m_owner = 0; m_hold = 0; m_ptr = 0; m_to = 0;
    end else if (m_phase == 0) begin
      m_to = 0;
      if (r != 0) begin
        m_owner = pick(r, rr); m_phase = 1; m_hold = 1;
      end
    end else if (m_phase == 1) begin
      own = r[m_owner];
      if (d || !own || m_hold == MAX_HOLD) begin
        m_phase = 2; m_to = !d && own; m_ptr = (m_owner + 1) % 4;
      end else m_hold++;
    end else begin
      m_phase = 0; m_to = 0;
    end
  endtask
  task automatic step(input logic [3:0] r, input bit d, input bit rr, input bit rs);
    exp_t e;
    req = r; done = d; rr_en = rr; rst = rs;
    model(r, d, rr, rs);
    e.gnt = m_phase == 1 ? 4'(1 << m_owner) : 4'b0000;
    e.id = 2'(m_owner);
    e.busy = m_phase == 1;
    e.to = m_to;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("gnt", gnt, e.gnt);
      chk("busy", busy, e.busy);
      chk("timeout", timeout, e.to);
      if (e.busy) chk("gnt_id", gnt_id, e.id);
      chk("onehot", $countones(gnt) <= 1, 1);
      chk("busy_eq", busy, gnt != 0);
    end
  end
  initial begin
    logic [3:0] r;
    bit d, rr, rs;
    step(4'b0000, 0, 0, 1);
    step(4'b1010, 1, 1, 1);
    step(4'b1010, 0, 0, 0);
    step(4'b1010, 0, 0, 0);
    step(4'b1010, 0, 0, 0);
    step(4'b1010, 1, 0, 0);
    repeat (4) step(4'b1010, 0, 0, 0);
    repeat (20) step(4'b1111, 1, 1, 0);
    step(4'b0000, 0, 0, 1);
    repeat (12) step(4'b0100, 0, 0, 0);
    step(4'b0000, 0, 0, 1);
    repeat (8) step(4'b0100, 0, 0, 0);
    step(4'b0100, 1, 0, 0);
    repeat (3) step(4'b0100, 0, 0, 0);
    step(4'b0000, 0, 0, 1);
    step(4'b0010, 0, 0, 0);
    repeat (2) step(4'b1010, 0, 0, 0);
    repeat (5) step(4'b1000, 0, 0, 0);
    step(4'b1000, 0, 0, 1);
    repeat (4) step(4'b1111, 0, 1, 0);
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 1, 1);
    step(4'b0000, 0, 1, 1);
    repeat (6) step(4'b0001, 0, 1, 0);
    r = 4'b0000; rr = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
      if ($urandom_range(19) == 0) rr = ~rr;
      d = $urandom_range(9) == 0;
      rs = $urandom_range(299) == 0;
      step(r, d, rr, rs);
    end
    @(negedge clk);
    #1;
    chk("drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arbiter_4ch.md
ARBITER_4CH -- requirements
Module: arbiter_4ch

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles per owner (legal range 1..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 req  input  4  request lines, req[3]..req[0], level-sensitive.
REQ-005 done  input  1  current owner releases the resource; ignored outside GRANT.
REQ-006 rr_en  input  1  1 = round-robin priority, 0 = fixed priority (req[3] highest, req[0] lowest).
REQ-007 gnt  output  4  one-hot grant, registered.
REQ-008 gnt_id  output  2  binary index of the granted requester, registered; valid only while busy=1.
REQ-009 busy  output  1  high while any gnt bit is high.
REQ-010 timeout  output  1  one-cycle pulse on a forced release by MAX_HOLD.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT, RELEASE.
REQ-012 IDLE: if req != 0 at an edge, the block SHALL enter GRANT and drive gnt/gnt_id/busy for the winner from that edge (1-cycle latency); otherwise it SHALL stay in IDLE with gnt=0.
REQ-013 Fixed mode (rr_en=0): the winner SHALL be the highest set index of req.
REQ-014 Round-robin mode (rr_en=1): the search SHALL start at pointer ptr and proceed ptr, ptr+1, ... modulo 4; the first set bit wins.
REQ-015 ptr SHALL be 2 bits; it SHALL update to (owner+1) mod 4 on the edge leaving GRANT, and SHALL update in both modes.
REQ-016 rr_en SHALL be sampled only at the IDLE->GRANT decision; changes during GRANT SHALL have no effect on the current owner.
REQ-017 GRANT: a 4-bit hold counter SHALL be 1 in the first grant cycle and increment each further grant cycle.
REQ-018 GRANT exit to RELEASE SHALL occur at the edge where any of these holds: done=1; req[owner]=0; hold counter == MAX_HOLD.
REQ-019 timeout SHALL pulse high for exactly the RELEASE cycle, and only when the exit was caused solely by the counter (done=0 and req[owner]=1).
REQ-020 If done=1 and the counter reaches MAX_HOLD at the same edge, done SHALL take precedence and timeout SHALL stay 0.
REQ-021 gnt SHALL therefore be high for at most MAX_HOLD consecutive cycles per grant.
REQ-022 RELEASE: gnt=0 and busy=0 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-023 gnt SHALL never have more than one bit set; gnt_id SHALL equal the index of the set bit whenever busy=1.
REQ-024 New or dropped requests from non-owners during GRANT SHALL not affect the current grant.
REQ-025 A requester still asserting req after RELEASE SHALL be eligible again; in round-robin mode it SHALL lose to any other pending requester.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set: state=IDLE, gnt=0000, gnt_id=00, busy=0, timeout=0, ptr=00, hold counter=0.
REQ-027 rst asserted mid-GRANT SHALL drop gnt on that edge with no RELEASE cycle and no timeout pulse.
REQ-028 rst SHALL take priority over all other inputs.

Verification
REQ-029 After reset, rr_en=0, req=1010 -> gnt=1000, gnt_id=11, busy=1 one cycle later; with done pulsed -> RELEASE cycle (gnt=0000), then gnt=1000 again.
REQ-030 rr_en=1, req=1111 held, done pulsed each grant -> grant order 0001, 0010, 0100, 1000, 0001, with one idle/release gap of gnt=0000 between each grant.
REQ-031 MAX_HOLD=8, req=0100 held, done=0 -> gnt=0100 for exactly 8 cycles, then timeout=1 for 1 cycle with gnt=0000.
REQ-032 done=1 in the 8th grant cycle with MAX_HOLD=8 -> release with timeout=0.
REQ-033 Owner 0010 drops req mid-grant while req[3]=1 -> release on the next edge, then gnt=1000; rst=1 mid-grant -> gnt=0000 on that edge and ptr=00.
REQ-034 All scenarios -> gnt is one-hot or zero every cycle, and busy is equivalent to (gnt != 0000).
